// File: rtl/vga_pkg.sv
// Shared VGA constants: active-area defaults, RGB565 colours, palette and the
// no-request coordinate code used by the timing controller.
package vga_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  localparam logic [9:0] PIX_INVALID = 10'h3ff;

  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t ORANGE  = 16'hFC00;
  localparam rgb565_t BLACK   = 16'h0000;

  function automatic rgb565_t palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = RED;
      3'd1:    palette = YELLOW;
      3'd2:    palette = GREEN;
      3'd3:    palette = CYAN;
      3'd4:    palette = BLUE;
      3'd5:    palette = MAGENTA;
      3'd6:    palette = WHITE;
      default: palette = ORANGE;
    endcase
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position/direction state that steps on each
// update strobe and clamps to the edge on a bounce; bounce is a same-cycle pulse.
module vga_bounce_axis #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 200,
  parameter int STEP  = 2
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       i_upd,
  output logic [9:0] o_pos,
  output logic       o_dir,
  output logic       o_bounce
);
  import vga_pkg::*;

  logic [9:0]  r_pos;
  logic        r_dir;
  logic [10:0] w_far_sum;
  logic        w_hit_far;
  logic        w_hit_near;

  assign w_far_sum  = {1'b0, r_pos} + 11'(SIZE) + 11'(STEP);
  assign w_hit_far  = r_dir  && (w_far_sum >= 11'(LIMIT));
  assign w_hit_near = !r_dir && ({1'b0, r_pos} <= 11'(STEP));

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pos <= 10'd0;
      r_dir <= 1'b1;
    end else if (i_upd) begin
      if (w_hit_far) begin
        r_pos <= 10'(LIMIT - SIZE);
        r_dir <= 1'b0;
      end else if (r_dir) begin
        r_pos <= r_pos + 10'(STEP);
      end else if (w_hit_near) begin
        r_pos <= 10'd0;
        r_dir <= 1'b1;
      end else begin
        r_pos <= r_pos - 10'(STEP);
      end
    end
  end

  assign o_pos    = r_pos;
  assign o_dir    = r_dir;
  assign o_bounce = i_upd && (w_hit_far || w_hit_near);

endmodule

// File: rtl/vga_pic_bounce.sv
// Pixel source for the VGA controller: a diagonally bouncing solid box that
// changes colour on every bounce; colour returned one cycle after the request.
module vga_pic_bounce #(
  parameter int          H_VALID   = vga_pkg::H_VALID_DEF,
  parameter int          V_VALID   = vga_pkg::V_VALID_DEF,
  parameter int          BOX_LEN   = 200,
  parameter int          BOX_WID   = 200,
  parameter int          STEP      = 2,
  parameter int          FRAME_DIV = 1,
  parameter logic [15:0] BG_COLOR  = 16'h0000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data
);
  import vga_pkg::*;

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic             r_tick;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_color_idx;
  logic [15:0]      r_pix_data;

  logic       w_div_last;
  logic       w_upd;
  logic [9:0] w_box_x, w_box_y;
  logic       w_dir_x, w_dir_y;
  logic       w_bounce_x, w_bounce_y;
  logic       w_invalid;
  logic       w_in_box;

  assign w_div_last = (r_div == DIV_W'(FRAME_DIV - 1));
  assign w_upd      = r_tick && w_div_last;

  vga_bounce_axis #(.LIMIT(H_VALID), .SIZE(BOX_LEN), .STEP(STEP)) u_axis_x (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .i_upd    (w_upd),
    .o_pos    (w_box_x),
    .o_dir    (w_dir_x),
    .o_bounce (w_bounce_x)
  );

  vga_bounce_axis #(.LIMIT(V_VALID), .SIZE(BOX_WID), .STEP(STEP)) u_axis_y (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .i_upd    (w_upd),
    .o_pos    (w_box_y),
    .o_dir    (w_dir_y),
    .o_bounce (w_bounce_y)
  );

  assign w_invalid = (pix_x == PIX_INVALID) || (pix_y == PIX_INVALID);
  assign w_in_box  = ({1'b0, pix_x} >= {1'b0, w_box_x}) &&
                     ({1'b0, pix_x} <  {1'b0, w_box_x} + 11'(BOX_LEN)) &&
                     ({1'b0, pix_y} >= {1'b0, w_box_y}) &&
                     ({1'b0, pix_y} <  {1'b0, w_box_y} + 11'(BOX_WID));

  // Tick is registered so the move lands one cycle later, inside blanking.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick      <= 1'b0;
      r_div       <= '0;
      r_color_idx <= 3'd0;
      r_pix_data  <= 16'h0000;
    end else begin
      r_tick <= (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
      if (r_tick)
        r_div <= w_div_last ? '0 : r_div + 1'b1;
      // A corner hit bounces both axes but advances the colour only once.
      if (w_bounce_x || w_bounce_y)
        r_color_idx <= r_color_idx + 3'd1;
      if (w_invalid)
        r_pix_data <= 16'h0000;
      else if (w_in_box)
        r_pix_data <= palette(r_color_idx);
      else
        r_pix_data <= BG_COLOR;
    end
  end

  assign pix_data = r_pix_data;

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Directed bench: default box, a corner-hit geometry and a divided frame rate
// driven with the same coordinate stream.
module tb_vga_pic_bounce;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x = 10'h3ff;
  logic [9:0]  pix_y = 10'h3ff;
  logic [15:0] d_def, d_cor, d_div;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  always #20 vga_clk = ~vga_clk;

  vga_pic_bounce dut_def (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(d_def)
  );
  vga_pic_bounce #(.BOX_LEN(360)) dut_cor (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(d_cor)
  );
  vga_pic_bounce #(.FRAME_DIV(3)) dut_div (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(d_div)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y);
    @(negedge vga_clk);
    pix_x = x;
    pix_y = y;
    @(negedge vga_clk);
  endtask

  task automatic tick_to(input int n);
    while (ticks < n) begin
      @(negedge vga_clk);
      pix_x = 10'd639;
      pix_y = 10'd479;
      @(negedge vga_clk);
      pix_x = 10'h3ff;
      pix_y = 10'h3ff;
      ticks++;
    end
  endtask

  initial begin
    // Reset with an in-box request applied
    pix_x = 10'd5;
    pix_y = 10'd5;
    repeat (3) @(negedge vga_clk);
    chk("rst_def", d_def, 16'h0000);
    chk("rst_cor", d_cor, 16'h0000);
    chk("rst_div", d_div, 16'h0000);
    sys_rst_n = 1'b1;

    probe(10'd5, 10'd5);     chk("px_5_5", d_def, 16'hF800);
    probe(10'd199, 10'd199); chk("px_199_199", d_def, 16'hF800);
    probe(10'd200, 10'd5);   chk("px_200_5", d_def, 16'h0000);
    chk("px_200_5_cor", d_cor, 16'hF800);
    probe(10'h3ff, 10'd10);  chk("inv_x", d_def, 16'h0000);
    probe(10'd10, 10'h3ff);  chk("inv_y", d_def, 16'h0000);

    // No tick from invalid coords or a truncated frame
    probe(10'h3ff, 10'h3ff);
    probe(10'd639, 10'd478);
    probe(10'd0, 10'd0);     chk("no_tick_0_0", d_def, 16'hF800);

    // First tick with exact latency: request one cycle after sees old box
    @(negedge vga_clk);
    pix_x = 10'd639;
    pix_y = 10'd479;
    @(negedge vga_clk);
    pix_x = 10'd1;
    pix_y = 10'd1;
    ticks++;
    @(negedge vga_clk);
    chk("lat_old_pos", d_def, 16'hF800);
    @(negedge vga_clk);
    chk("lat_new_pos", d_def, 16'h0000);
    chk("div_no_move", d_div, 16'hF800);
    probe(10'd2, 10'd2);     chk("t1_2_2", d_def, 16'hF800);

    tick_to(2);
    probe(10'd1, 10'd1);     chk("div_t2_1_1", d_div, 16'hF800);
    tick_to(3);
    probe(10'd1, 10'd1);     chk("div_t3_1_1", d_div, 16'h0000);
    probe(10'd2, 10'd2);     chk("div_t3_2_2", d_div, 16'hF800);
    probe(10'd5, 10'd5);     chk("t3_5_5", d_def, 16'h0000);
    probe(10'd6, 10'd6);     chk("t3_6_6", d_def, 16'hF800);

    tick_to(139);
    probe(10'd278, 10'd278); chk("t139_278", d_def, 16'hF800);
    probe(10'd278, 10'd277); chk("t139_277", d_def, 16'h0000);
    probe(10'd92, 10'd92);   chk("div_t139_in", d_div, 16'hF800);
    probe(10'd91, 10'd92);   chk("div_t139_out", d_div, 16'h0000);

    tick_to(140);
    probe(10'd280, 10'd280); chk("t140_def", d_def, 16'hFFE0);
    chk("t140_cor", d_cor, 16'hFFE0);
    probe(10'd280, 10'd279); chk("t140_def_above", d_def, 16'h0000);
    probe(10'd279, 10'd280); chk("t140_cor_left", d_cor, 16'h0000);
    probe(10'd639, 10'd280); chk("t140_cor_right", d_cor, 16'hFFE0);

    tick_to(141);
    probe(10'd278, 10'd278); chk("t141_cor_in", d_cor, 16'hFFE0);
    probe(10'd277, 10'd278); chk("t141_cor_out", d_cor, 16'h0000);

    tick_to(220);
    probe(10'd440, 10'd120); chk("t220_def", d_def, 16'h07E0);
    probe(10'd439, 10'd120); chk("t220_def_left", d_def, 16'h0000);
    probe(10'd639, 10'd120); chk("t220_def_right", d_def, 16'h07E0);
    probe(10'd120, 10'd120); chk("t220_cor", d_cor, 16'hFFE0);
    probe(10'd146, 10'd146); chk("t220_div", d_div, 16'hF800);

    tick_to(280);
    probe(10'd320, 10'd0);   chk("t280_def", d_def, 16'h07FF);
    probe(10'd319, 10'd0);   chk("t280_def_left", d_def, 16'h0000);

    // Asynchronous reset in the middle of a line
    @(posedge vga_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_def", d_def, 16'h0000);
    chk("mid_rst_cor", d_cor, 16'h0000);
    repeat (3) @(negedge vga_clk);
    sys_rst_n = 1'b1;
    ticks = 0;
    probe(10'd0, 10'd0);     chk("post_rst_0_0", d_def, 16'hF800);
    chk("post_rst_div", d_div, 16'hF800);
    probe(10'd200, 10'd0);   chk("post_rst_200_0", d_def, 16'h0000);
    tick_to(1);
    probe(10'd2, 10'd2);     chk("post_rst_t1_in", d_def, 16'hF800);
    probe(10'd1, 10'd1);     chk("post_rst_t1_out", d_def, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pic_bounce.md
# vga_pic_bounce

Pixel-source stage that sits directly upstream of the VGA timing controller. It consumes the controller's pixel request coordinates (`pix_x`, `pix_y`) and returns a registered RGB565 colour (`pix_data`) one clock later. The picture is a solid box on a flat background. The box moves diagonally, advances once per frame (or every `FRAME_DIV` frames), bounces off the active-area edges and changes colour on each bounce.

## Interface
Parameters:
- `H_VALID`, 640, active pixels per line
- `V_VALID`, 480, active lines per frame
- `BOX_LEN`, 200, box width in pixels (x); must satisfy `BOX_LEN` + `STEP` ≤ `H_VALID`
- `BOX_WID`, 200, box height in lines (y); must satisfy `BOX_WID` + `STEP` ≤ `V_VALID`
- `STEP`, 2, pixels moved per update on each axis, ≥ 1
- `FRAME_DIV`, 1, number of frames per position update, ≥ 1
- `BG_COLOR`, 16'h0000, background colour

Ports:
- `vga_clk`, in, 1, pixel clock, 25 MHz
- `sys_rst_n`, in, 1, reset; asynchronous, active-low
- `pix_x`, in, 10, requested x; 10'h3ff means no request
- `pix_y`, in, 10, requested y; 10'h3ff means no request
- `pix_data`, out, 16, RGB565 colour for the request presented one cycle earlier

## Operation
- **State registers:**
  - `box_x`, `box_y`: box top-left corner, 10 bits each; reset value 0, 0
  - `dir_x`, `dir_y`: 1 means increasing; reset value 1, 1
  - `color_idx`: 3 bits; reset value 0
  - frame divider counter: reset value 0
- **Palette (`color_idx` 0..7):** F800 red, FFE0 yellow, 07E0 green, 07FF cyan, 001F blue, F81F magenta, FFFF white, FC00 orange.
- **Frame tick:** one-cycle registered pulse, asserted the cycle after `pix_x` == `H_VALID`-1 and `pix_y` == `V_VALID`-1 (the last request of a frame).
- **Divider:** increments on each tick and wraps at `FRAME_DIV`-1. A position update happens on a tick when the divider equals `FRAME_DIV`-1. When `FRAME_DIV` = 1, every tick updates.
- **Per-axis update (x shown; y is the same with `BOX_WID` and `V_VALID`):**
  - All comparisons use 11-bit arithmetic.
  - `dir_x` = 1 and `box_x` + `BOX_LEN` + `STEP` ≥ `H_VALID`: `box_x` ← `H_VALID`-`BOX_LEN`, `dir_x` ← 0, bounce.
  - `dir_x` = 1 otherwise: `box_x` ← `box_x` + `STEP`.
  - `dir_x` = 0 and `box_x` ≤ `STEP`: `box_x` ← 0, `dir_x` ← 1, bounce.
  - `dir_x` = 0 otherwise: `box_x` ← `box_x` - `STEP`.
- **Colour change:** `color_idx` increments by exactly 1 when either axis bounces, including a corner hit where both axes bounce in the same update. It wraps 7 → 0.
- **Pixel select (registered):**
  - `pix_x` or `pix_y` == 3ff: output 0.
  - Else `box_x` ≤ `pix_x` < `box_x`+`BOX_LEN` and `box_y` ≤ `pix_y` < `box_y`+`BOX_WID`: output `palette[color_idx]`.
  - Else: output `BG_COLOR`.

## Timing
- `pix_data` reset value: 0.
- Latency from coordinate to `pix_data` is exactly 1 cycle. This matches the controller's request, which leads its valid window by one cycle.
- The position update lands 2 cycles after the last-pixel request, inside blanking. No active frame ever mixes two box positions.
- The frame tick fires only on an exact match of both last-pixel coordinates. A frame that is truncated or never reaches the last pixel causes no update.
- Asynchronous reset mid-frame returns all state to reset values immediately. The first frame after release draws the box at (0, 0).

## Structure
- Shared package `vga_pkg`: `H_VALID`/`V_VALID` defaults, the RGB565 colour constants, the 8-entry palette, and the 10'h3ff invalid-coordinate code. The controller uses the same package.
- One sub-module, `vga_bounce_axis`, instantiated twice (x and y):
  - Parameters: `LIMIT`, `SIZE`, `STEP`.
  - Inputs: clock, reset, update strobe.
  - Outputs: position, direction, bounce pulse.
- The top level holds the tick detector, the frame divider, `color_idx`, the palette mux and the output register.

## Test plan
1. **Reset and first pixels:** reset, then drive (5,5), (199,199), (200,5). Required: `pix_data` = 0 during reset; one cycle after each request the outputs are F800, F800 and 0000.
2. **Invalid coordinates:** drive (3ff,10) and (10,3ff). Required: 0000 one cycle later. A request (3ff,3ff) must not produce a frame tick.
3. **Single update:** one tick, i.e. a request at (639,479). Required: box at (2,2) two cycles later; a request at (1,1) returns 0000 and (2,2) returns F800. With `FRAME_DIV` = 3, the box moves only on the 3rd, 6th, ... tick.
4. **Bounces with defaults:**
   - Tick 139: `box_y` = 278.
   - Tick 140: `box_y` = 280, `dir_y` = 0, `color_idx` = 1 (box colour FFE0).
   - Tick 220: `box_x` = 440, `dir_x` = 0, `color_idx` = 2.
   - Tick 280: `box_y` = 0, `dir_y` = 1, `color_idx` = 3.
5. **Corner hit:** `BOX_LEN` = 360, `BOX_WID` = 200. Required at tick 140: `box_x` = `box_y` = 280, both directions flip, `color_idx` goes 0 → 1 (not 2).
6. **Reset mid-operation:** after 50 ticks, assert `sys_rst_n` low at mid-frame for 3 cycles. Required: `pix_data` = 0 immediately; `box_x` = `box_y` = 0, `color_idx` = 0, directions 1; request (0,0) returns F800 after release.
